// File: rtl/demux_reg_bank.sv
// demux_reg_bank
//   32-entry x WIDTH register bank with a single decoded write port and a
//   hardware clear sweep. Every entry is presented in parallel on R0..R31
//   so the read-side 32x1 mux can select from them.
//
//   Ports:
//     CLK   in   clock, rising edge
//     RST   in   asynchronous active-low reset
//     WE    in   write request
//     ADDR  in   write address [4:0]
//     D     in   write data [WIDTH-1:0]
//     CLR   in   start clear sweep (wins over a coincident WE)
//     ACK   out  registered one-cycle pulse per accepted write
//     BUSY  out  clear sweep in progress (exactly 32 cycles)
//     R0..R31 out registered entry contents

// Single storage entry: clear has priority over load.
module demux_reg_entry #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ld,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)     q <= '0;
        else if (clr) q <= '0;
        else if (ld)  q <= d;
    end
endmodule

module demux_reg_bank #(
    parameter int WIDTH   = 32,
    parameter bit ZERO_R0 = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             WE,
    input  logic [4:0]       ADDR,
    input  logic [WIDTH-1:0] D,
    input  logic             CLR,
    output logic             ACK,
    output logic             BUSY,
    output logic [WIDTH-1:0] R0,  R1,  R2,  R3,  R4,  R5,  R6,  R7,
    output logic [WIDTH-1:0] R8,  R9,  R10, R11, R12, R13, R14, R15,
    output logic [WIDTH-1:0] R16, R17, R18, R19, R20, R21, R22, R23,
    output logic [WIDTH-1:0] R24, R25, R26, R27, R28, R29, R30, R31
);
    localparam int NUM_ENT = 32;

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t     state;
    logic [4:0] cnt;

    logic [NUM_ENT-1:0][WIDTH-1:0] rq;

    // Write is accepted only in IDLE and only when no clear is requested.
    logic wr_en;
    logic sweep;
    assign wr_en = (state == IDLE) && WE && !CLR;
    assign sweep = (state == SWEEP);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
            cnt   <= '0;
            ACK   <= 1'b0;
            BUSY  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ACK <= wr_en;
                    if (CLR) begin
                        state <= SWEEP;
                        BUSY  <= 1'b1;
                        cnt   <= '0;
                    end
                end
                SWEEP: begin
                    ACK <= 1'b0;
                    cnt <= cnt + 5'd1;   // wraps to 0 after entry 31
                    if (cnt == 5'd31) begin
                        state <= IDLE;
                        BUSY  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    ACK   <= 1'b0;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

    // One-hot decode per entry: load from ADDR, clear from the sweep counter.
    for (genvar i = 0; i < NUM_ENT; i++) begin : g_ent
        if (ZERO_R0 && i == 0) begin : g_zero
            assign rq[i] = '0;
        end else begin : g_reg
            logic ld, clr;
            assign ld  = wr_en && (ADDR == 5'(i));
            assign clr = sweep && (cnt == 5'(i));
            demux_reg_entry #(.WIDTH(WIDTH)) u_ent (
                .CLK (CLK),
                .RST (RST),
                .ld  (ld),
                .clr (clr),
                .d   (D),
                .q   (rq[i])
            );
        end
    end

    assign R0  = rq[0];  assign R1  = rq[1];  assign R2  = rq[2];  assign R3  = rq[3];
    assign R4  = rq[4];  assign R5  = rq[5];  assign R6  = rq[6];  assign R7  = rq[7];
    assign R8  = rq[8];  assign R9  = rq[9];  assign R10 = rq[10]; assign R11 = rq[11];
    assign R12 = rq[12]; assign R13 = rq[13]; assign R14 = rq[14]; assign R15 = rq[15];
    assign R16 = rq[16]; assign R17 = rq[17]; assign R18 = rq[18]; assign R19 = rq[19];
    assign R20 = rq[20]; assign R21 = rq[21]; assign R22 = rq[22]; assign R23 = rq[23];
    assign R24 = rq[24]; assign R25 = rq[25]; assign R26 = rq[26]; assign R27 = rq[27];
    assign R28 = rq[28]; assign R29 = rq[29]; assign R30 = rq[30]; assign R31 = rq[31];
endmodule

// File: tb/tb_demux_reg_bank.sv
module tb_demux_reg_bank;
    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        WE = 1'b0;
    logic [4:0]  ADDR = '0;
    logic [31:0] D = '0;
    logic        CLR = 1'b0;
    logic        ACK, BUSY;
    logic [31:0] r [32];

    int ncmp = 0;
    int nerr = 0;

    always #5 CLK = ~CLK;

    demux_reg_bank #(.WIDTH(32), .ZERO_R0(1'b1)) dut (
        .CLK(CLK), .RST(RST), .WE(WE), .ADDR(ADDR), .D(D), .CLR(CLR),
        .ACK(ACK), .BUSY(BUSY),
        .R0(r[0]),   .R1(r[1]),   .R2(r[2]),   .R3(r[3]),
        .R4(r[4]),   .R5(r[5]),   .R6(r[6]),   .R7(r[7]),
        .R8(r[8]),   .R9(r[9]),   .R10(r[10]), .R11(r[11]),
        .R12(r[12]), .R13(r[13]), .R14(r[14]), .R15(r[15]),
        .R16(r[16]), .R17(r[17]), .R18(r[18]), .R19(r[19]),
        .R20(r[20]), .R21(r[21]), .R22(r[22]), .R23(r[23]),
        .R24(r[24]), .R25(r[25]), .R26(r[26]), .R27(r[27]),
        .R28(r[28]), .R29(r[29]), .R30(r[30]), .R31(r[31])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        WE = 1'b1; ADDR = a; D = d;
        step();
    endtask

    task automatic fill_all(input logic [31:0] d);
        for (int i = 0; i < 32; i++) wr(5'(i), d);
        WE = 1'b0;
    endtask

    task automatic all_zero(input string tag);
        for (int i = 0; i < 32; i++) chk($sformatf("%s_r%0d", tag, i), r[i], 32'h0);
    endtask

    initial begin
        // Reset state
        #2;
        all_zero("rst_init");
        chk("rst_ack", {31'h0, ACK}, 32'h0);
        chk("rst_busy", {31'h0, BUSY}, 32'h0);
        step();
        RST = 1'b1;

        // Asynchronous reset mid-cycle after loading R5
        wr(5'd5, 32'hDEADBEEF);
        WE = 1'b0;
        chk("pre_rst_r5", r[5], 32'hDEADBEEF);
        chk("pre_rst_ack", {31'h0, ACK}, 32'h1);
        #2 RST = 1'b0;
        #1;
        chk("arst_r5", r[5], 32'h0);
        chk("arst_ack", {31'h0, ACK}, 32'h0);
        chk("arst_busy", {31'h0, BUSY}, 32'h0);
        RST = 1'b1;
        step();

        // Write/decode sweep n=1..31, ACK continuous
        for (int n = 1; n < 32; n++) begin
            wr(5'(n), 32'(n));
            chk($sformatf("wr_ack%0d", n), {31'h0, ACK}, 32'h1);
            chk($sformatf("wr_r%0d", n), r[n], 32'(n));
            if (n < 31) chk($sformatf("wr_next%0d", n), r[n+1], 32'h0);
        end
        wr(5'd0, 32'hFFFFFFFF);
        chk("r0_ack", {31'h0, ACK}, 32'h1);
        chk("r0_zero", r[0], 32'h0);
        WE = 1'b0;
        step();
        chk("idle_ack", {31'h0, ACK}, 32'h0);
        for (int i = 1; i < 32; i++) chk($sformatf("hold_r%0d", i), r[i], 32'(i));

        // Clear sweep
        fill_all(32'hA5A5A5A5);
        chk("fill_r31", r[31], 32'hA5A5A5A5);
        CLR = 1'b1;
        step();
        CLR = 1'b0;
        for (int k = 0; k < 32; k++) begin
            chk($sformatf("sw_busy%0d", k), {31'h0, BUSY}, 32'h1);
            step();
            chk($sformatf("sw_r%0d", k), r[k], 32'h0);
            if (k < 31) chk($sformatf("sw_nxt%0d", k+1), r[k+1], 32'hA5A5A5A5);
        end
        chk("sw_done_busy", {31'h0, BUSY}, 32'h0);
        all_zero("sw_done");

        // WE and CLR ignored during sweep
        fill_all(32'h11111111);
        CLR = 1'b1;
        step();
        CLR = 1'b0;
        for (int k = 0; k < 32; k++) begin
            if (k >= 3 && k <= 10) begin
                WE = 1'b1; ADDR = 5'd7; D = 32'h12345678; CLR = 1'b1;
            end else begin
                WE = 1'b0; CLR = 1'b0;
            end
            step();
            chk($sformatf("ign_ack%0d", k), {31'h0, ACK}, 32'h0);
            chk($sformatf("ign_busy%0d", k), {31'h0, BUSY}, (k < 31) ? 32'h1 : 32'h0);
        end
        WE = 1'b0; CLR = 1'b0;
        chk("ign_r7", r[7], 32'h0);
        all_zero("ign_done");

        // Simultaneous CLR+WE in IDLE
        WE = 1'b1; ADDR = 5'd4; D = 32'h1; CLR = 1'b1;
        step();
        WE = 1'b0; CLR = 1'b0;
        chk("sim_ack", {31'h0, ACK}, 32'h0);
        chk("sim_busy", {31'h0, BUSY}, 32'h1);
        chk("sim_r4_now", r[4], 32'h0);
        for (int k = 0; k < 32; k++) step();
        chk("sim_busy_end", {31'h0, BUSY}, 32'h0);
        chk("sim_r4", r[4], 32'h0);

        // Reset mid-sweep
        fill_all(32'h77777777);
        CLR = 1'b1;
        step();
        CLR = 1'b0;
        for (int k = 0; k < 15; k++) step();
        chk("mid_busy", {31'h0, BUSY}, 32'h1);
        chk("mid_r20", r[20], 32'h77777777);
        #2 RST = 1'b0;
        #1;
        chk("mid_rst_busy", {31'h0, BUSY}, 32'h0);
        all_zero("mid_rst");
        RST = 1'b1;
        wr(5'd20, 32'h55);
        WE = 1'b0;
        chk("post_r20", r[20], 32'h55);
        chk("post_ack", {31'h0, ACK}, 32'h1);
        chk("post_busy", {31'h0, BUSY}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
